// File: rtl/dpu_seq.sv
// dpu_seq: command sequencer driving an external 4-bit ALU.
// Commands queue in a 4-entry FIFO and execute one per cycle in RUN.
// The final accumulator, an executed-command count and an overflow flag
// are then presented with a valid/ready handshake.
// Optional feature macro: DPU_SEQ_OVF_EN enables the sticky add/sub overflow flag;
// when it is undefined, res_ovf is tied to 0.
module dpu_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [3:0] cmd_imm,
  input  logic       cmd_last,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [2:0] alu_op,
  input  logic [3:0] alu_result,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [3:0] res_data,
  output logic [3:0] res_count,
  output logic       res_ovf,
  output logic       busy
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam int unsigned FifoDepth = 4;

  state_e      state_q, state_d;

  // FIFO storage: entry = {op[2:0], imm[3:0], last}
  logic [7:0]  fifo_mem_q [FifoDepth];
  logic [1:0]  wr_ptr_q;
  logic [1:0]  rd_ptr_q;
  logic [2:0]  fifo_cnt_q;

  logic [3:0]  acc_q;
  logic [3:0]  count_q;

  logic        push;
  logic        pop;
  logic        fifo_empty;
  logic        exec;
  logic        res_hs;
  logic [7:0]  head;
  logic [2:0]  head_op;
  logic [3:0]  head_imm;
  logic        head_last;

  // Ready depends on occupancy alone, so a push can never land on a full FIFO.
  assign cmd_ready  = (fifo_cnt_q < 3'd4);
  assign push       = cmd_valid & cmd_ready;
  assign fifo_empty = (fifo_cnt_q == 3'd0);

  assign head      = fifo_mem_q[rd_ptr_q];
  assign head_op   = head[7:5];
  assign head_imm  = head[4:1];
  assign head_last = head[0];

  // A command executes (and is popped) on every RUN cycle with a non-empty FIFO.
  assign exec   = (state_q == StRun) && !fifo_empty;
  assign pop    = exec;
  assign res_hs = (state_q == StDone) && res_ready;

  // FIFO pointers, occupancy and storage; pointers wrap naturally at 2 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= 2'd0;
      rd_ptr_q   <= 2'd0;
      fifo_cnt_q <= 3'd0;
      for (int i = 0; i < FifoDepth; i++) begin
        fifo_mem_q[i] <= 8'd0;
      end
    end else begin
      if (push) begin
        fifo_mem_q[wr_ptr_q] <= {cmd_op, cmd_imm, cmd_last};
        wr_ptr_q             <= wr_ptr_q + 2'd1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 2'd1;
      end
      case ({push, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + 3'd1;
        2'b01:   fifo_cnt_q <= fifo_cnt_q - 3'd1;
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (exec && head_last) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (res_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs: ALU operands are only live while a command executes.
  always_comb begin
    alu_a     = acc_q;
    alu_op    = 3'b000;
    alu_b     = 4'd0;
    res_valid = 1'b0;
    busy      = 1'b1;
    unique case (state_q)
      StIdle: begin
        busy = 1'b0;
      end
      StRun: begin
        if (exec) begin
          alu_op = head_op;
          alu_b  = head_imm;
        end
      end
      StDone: begin
        res_valid = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign res_data  = acc_q;
  assign res_count = count_q;

  // Accumulator and saturating executed-command counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q   <= 4'd0;
      count_q <= 4'd0;
    end else if (res_hs) begin
      acc_q   <= 4'd0;
      count_q <= 4'd0;
    end else if (exec) begin
      acc_q <= alu_result;
      if (count_q != 4'd15) begin
        count_q <= count_q + 4'd1;
      end
    end
  end

`ifdef DPU_SEQ_OVF_EN
  logic       ovf_q;
  logic [4:0] add_sum;
  logic       ovf_hit;

  // Overflow is derived from acc and imm directly; alu_result is never trusted.
  assign add_sum = {1'b0, acc_q} + {1'b0, head_imm};
  assign ovf_hit = exec && (((head_op == 3'b101) && add_sum[4]) ||
                            ((head_op == 3'b100) && (acc_q < head_imm)));

  // Sticky overflow flag, cleared only by the result handshake or reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (res_hs) begin
      ovf_q <= 1'b0;
    end else if (ovf_hit) begin
      ovf_q <= 1'b1;
    end
  end

  assign res_ovf = ovf_q;
`else
  assign res_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_dpu_seq.sv
// Self-checking bench for dpu_seq with a scoreboard of expected program results.
module tb_dpu_seq;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [3:0] cmd_imm;
  logic       cmd_last;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [2:0] alu_op;
  logic [3:0] alu_result;
  logic       res_valid;
  logic       res_ready;
  logic [3:0] res_data;
  logic [3:0] res_count;
  logic       res_ovf;
  logic       busy;

  int total;
  int bad;

  // Expected / observed results packed as {ovf, count[3:0], data[3:0]}
  logic [8:0] exp_q[$];
  logic [8:0] got_q[$];
  logic [3:0] run_a_q[$];

  // Reference model of the program being pushed
  logic [3:0] m_acc;
  logic [3:0] m_cnt;
  logic       m_ovf;

  dpu_seq u_dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_imm    (cmd_imm),
    .cmd_last   (cmd_last),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_count  (res_count),
    .res_ovf    (res_ovf),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External ALU
  always_comb begin
    case (alu_op)
      3'b000:  alu_result = alu_a;
      3'b001:  alu_result = alu_a | alu_b;
      3'b010:  alu_result = alu_a ^ alu_b;
      3'b011:  alu_result = alu_a & alu_b;
      3'b100:  alu_result = alu_a - alu_b;
      3'b101:  alu_result = alu_a + alu_b;
      default: alu_result = alu_b;
    endcase
  end

  // Monitor on the falling edge: record executing alu_a values and handshaken results
  always @(negedge clk) begin
    if (!rst) begin
      if (busy && !res_valid && alu_op != 3'b000) run_a_q.push_back(alu_a);
      if (res_valid && res_ready) got_q.push_back({res_ovf, res_count, res_data});
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  task automatic model_clear();
    m_acc = 4'd0;
    m_cnt = 4'd0;
    m_ovf = 1'b0;
  endtask

  // Push one command (called at posedge+1) and advance the model when accepted
  task automatic push_cmd(input logic [2:0] op, input logic [3:0] imm, input logic last);
    int n;
    n = 0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_imm   = imm;
    cmd_last  = last;
    while (!cmd_ready && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    if (!cmd_ready) begin
      total++;
      bad++;
      $display("FAIL push_timeout: cmd_ready=%0b want=1", cmd_ready);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
`ifdef DPU_SEQ_OVF_EN
    if (op == 3'b101 && ({1'b0, m_acc} + {1'b0, imm}) > 5'd15) m_ovf = 1'b1;
    if (op == 3'b100 && m_acc < imm) m_ovf = 1'b1;
`endif
    case (op)
      3'b000:  m_acc = m_acc;
      3'b001:  m_acc = m_acc | imm;
      3'b010:  m_acc = m_acc ^ imm;
      3'b011:  m_acc = m_acc & imm;
      3'b100:  m_acc = m_acc - imm;
      3'b101:  m_acc = m_acc + imm;
      default: m_acc = imm;
    endcase
    if (m_cnt != 4'd15) m_cnt = m_cnt + 4'd1;
    if (last) begin
      exp_q.push_back({m_ovf, m_cnt, m_acc});
      model_clear();
    end
  endtask

  // Bounded wait for the monitor to capture a result
  task automatic wait_result(output logic ok, output logic [8:0] g, output logic [8:0] e);
    int n;
    n = 0;
    while (got_q.size() == 0 && n < 120) begin
      @(posedge clk); #1;
      n++;
    end
    ok = (got_q.size() != 0) && (exp_q.size() != 0);
    g  = 9'd0;
    e  = 9'd0;
    if (ok) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL rst_cmd_ready: got=%0b want=1", cmd_ready); end
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL rst_res_valid: got=%0b want=0", res_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got=%0b want=0", busy); end
    total++; if (res_data !== 4'd0) begin bad++; $display("FAIL rst_res_data: got=%0d want=0", res_data); end
    total++; if (res_count !== 4'd0) begin bad++; $display("FAIL rst_res_count: got=%0d want=0", res_count); end
    total++; if (res_ovf !== 1'b0) begin bad++; $display("FAIL rst_res_ovf: got=%0b want=0", res_ovf); end
    total++; if (alu_op !== 3'd0) begin bad++; $display("FAIL rst_alu_op: got=%0d want=0", alu_op); end
    total++; if (alu_a !== 4'd0) begin bad++; $display("FAIL rst_alu_a: got=%0d want=0", alu_a); end
    total++; if (alu_b !== 4'd0) begin bad++; $display("FAIL rst_alu_b: got=%0d want=0", alu_b); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic ok;
    logic [8:0] g, e;
    logic [3:0] exp_a [3];
    exp_a[0] = 4'd0; exp_a[1] = 4'd9; exp_a[2] = 4'd7;
    res_ready = 1'b1;
    run_a_q.delete();
    push_cmd(3'b110, 4'd9, 1'b0);
    push_cmd(3'b100, 4'd2, 1'b0);
    push_cmd(3'b010, 4'd5, 1'b1);
    wait_result(ok, g, e);
    total++;
    if (!ok) begin bad++; $display("FAIL basic_result: got=timeout want=result"); end
    else begin
      if (g[3:0] !== e[3:0]) begin bad++; $display("FAIL basic_data: got=%0d want=%0d", g[3:0], e[3:0]); end
      total++; if (g[7:4] !== e[7:4]) begin bad++; $display("FAIL basic_count: got=%0d want=%0d", g[7:4], e[7:4]); end
      total++; if (g[8] !== e[8]) begin bad++; $display("FAIL basic_ovf: got=%0b want=%0b", g[8], e[8]); end
    end
    repeat (4) @(posedge clk);
    #1;
    total++; if (got_q.size() != 0) begin bad++; $display("FAIL basic_one_pulse: got=%0d extra want=0", got_q.size()); end
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL basic_valid_low: got=%0b want=0", res_valid); end
    total++;
    if (run_a_q.size() != 3) begin
      bad++; $display("FAIL basic_alu_a_n: got=%0d want=3", run_a_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        total++;
        if (run_a_q[i] !== exp_a[i]) begin
          bad++; $display("FAIL basic_alu_a[%0d]: got=%0d want=%0d", i, run_a_q[i], exp_a[i]);
        end
      end
    end
  endtask

  task automatic test_ovf();
    logic ok;
    logic [8:0] g, e;
    res_ready = 1'b1;
    push_cmd(3'b110, 4'd12, 1'b0);
    push_cmd(3'b101, 4'd7, 1'b1);
    wait_result(ok, g, e);
    total++;
    if (!ok) begin bad++; $display("FAIL ovf_result: got=timeout want=result"); end
    else begin
      if (g[3:0] !== e[3:0]) begin bad++; $display("FAIL ovf_data: got=%0d want=%0d", g[3:0], e[3:0]); end
      total++; if (g[7:4] !== e[7:4]) begin bad++; $display("FAIL ovf_count: got=%0d want=%0d", g[7:4], e[7:4]); end
      total++; if (g[8] !== e[8]) begin bad++; $display("FAIL ovf_flag: got=%0b want=%0b", g[8], e[8]); end
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure();
    logic ok;
    logic [8:0] g, e;
    logic [3:0] exp_a [4];
    int n;
    exp_a[0] = 4'd0; exp_a[1] = 4'd3; exp_a[2] = 4'd5; exp_a[3] = 4'd4;
    res_ready = 1'b0;
    push_cmd(3'b101, 4'd5, 1'b1);
    n = 0;
    while (!res_valid && n < 50) begin @(posedge clk); #1; n++; end
    total++; if (res_valid !== 1'b1) begin bad++; $display("FAIL bp_done: got=%0b want=1", res_valid); end
    push_cmd(3'b001, 4'd3, 1'b0);
    push_cmd(3'b101, 4'd2, 1'b0);
    push_cmd(3'b100, 4'd1, 1'b0);
    push_cmd(3'b010, 4'd15, 1'b1);
    total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL bp_full: got=%0b want=0", cmd_ready); end
    e = exp_q[0];
    for (int i = 0; i < 5; i++) begin
      total++; if (res_valid !== 1'b1) begin bad++; $display("FAIL bp_hold_valid[%0d]: got=%0b want=1", i, res_valid); end
      total++; if (res_data !== e[3:0]) begin bad++; $display("FAIL bp_hold_data[%0d]: got=%0d want=%0d", i, res_data, e[3:0]); end
      total++; if (res_count !== e[7:4]) begin bad++; $display("FAIL bp_hold_count[%0d]: got=%0d want=%0d", i, res_count, e[7:4]); end
      @(posedge clk); #1;
    end
    run_a_q.delete();
    res_ready = 1'b1;
    @(posedge clk); #1;
    total++; if (res_data !== 4'd0) begin bad++; $display("FAIL bp_clr_acc: got=%0d want=0", res_data); end
    total++; if (res_count !== 4'd0) begin bad++; $display("FAIL bp_clr_count: got=%0d want=0", res_count); end
    total++; if (res_ovf !== 1'b0) begin bad++; $display("FAIL bp_clr_ovf: got=%0b want=0", res_ovf); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL bp_idle: got=%0b want=0", busy); end
    for (int k = 0; k < 2; k++) begin
      wait_result(ok, g, e);
      total++;
      if (!ok) begin bad++; $display("FAIL bp_result[%0d]: got=timeout want=result", k); end
      else begin
        if (g[3:0] !== e[3:0]) begin bad++; $display("FAIL bp_data[%0d]: got=%0d want=%0d", k, g[3:0], e[3:0]); end
        total++; if (g[7:4] !== e[7:4]) begin bad++; $display("FAIL bp_count[%0d]: got=%0d want=%0d", k, g[7:4], e[7:4]); end
        total++; if (g[8] !== e[8]) begin bad++; $display("FAIL bp_ovf[%0d]: got=%0b want=%0b", k, g[8], e[8]); end
      end
    end
    total++;
    if (run_a_q.size() != 4) begin
      bad++; $display("FAIL bp_alu_a_n: got=%0d want=4", run_a_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (run_a_q[i] !== exp_a[i]) begin
          bad++; $display("FAIL bp_alu_a[%0d]: got=%0d want=%0d", i, run_a_q[i], exp_a[i]);
        end
      end
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_saturate();
    logic ok;
    logic [8:0] g, e;
    res_ready = 1'b1;
    for (int i = 0; i < 17; i++) push_cmd(3'b101, 4'd1, (i == 16));
    wait_result(ok, g, e);
    total++;
    if (!ok) begin bad++; $display("FAIL sat_result: got=timeout want=result"); end
    else begin
      if (g[3:0] !== e[3:0]) begin bad++; $display("FAIL sat_data: got=%0d want=%0d", g[3:0], e[3:0]); end
      total++; if (g[7:4] !== e[7:4]) begin bad++; $display("FAIL sat_count: got=%0d want=%0d", g[7:4], e[7:4]); end
      total++; if (g[8] !== e[8]) begin bad++; $display("FAIL sat_ovf: got=%0b want=%0b", g[8], e[8]); end
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_midrun();
    logic ok;
    logic [8:0] g, e;
    res_ready = 1'b1;
    push_cmd(3'b110, 4'd3, 1'b0);
    push_cmd(3'b101, 4'd1, 1'b0);
    @(posedge clk); #1;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL mr_running: got=%0b want=1", busy); end
    #2;
    rst = 1'b1;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mr_busy: got=%0b want=0", busy); end
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL mr_cmd_ready: got=%0b want=1", cmd_ready); end
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL mr_res_valid: got=%0b want=0", res_valid); end
    total++; if (res_data !== 4'd0) begin bad++; $display("FAIL mr_res_data: got=%0d want=0", res_data); end
    total++; if (res_count !== 4'd0) begin bad++; $display("FAIL mr_res_count: got=%0d want=0", res_count); end
    total++; if (alu_a !== 4'd0) begin bad++; $display("FAIL mr_alu_a: got=%0d want=0", alu_a); end
    total++; if (alu_op !== 3'd0) begin bad++; $display("FAIL mr_alu_op: got=%0d want=0", alu_op); end
    model_clear();
    @(posedge clk); #1;
    rst = 1'b0;
    push_cmd(3'b101, 4'd6, 1'b1);
    wait_result(ok, g, e);
    total++;
    if (!ok) begin bad++; $display("FAIL mr_result: got=timeout want=result"); end
    else begin
      if (g[3:0] !== e[3:0]) begin bad++; $display("FAIL mr_data: got=%0d want=%0d", g[3:0], e[3:0]); end
      total++; if (g[7:4] !== e[7:4]) begin bad++; $display("FAIL mr_count: got=%0d want=%0d", g[7:4], e[7:4]); end
      total++; if (g[8] !== e[8]) begin bad++; $display("FAIL mr_ovf: got=%0b want=%0b", g[8], e[8]); end
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_stall();
    logic ok;
    logic [8:0] g, e;
    res_ready = 1'b1;
    push_cmd(3'b001, 4'd5, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL stall_busy[%0d]: got=%0b want=1", i, busy); end
      total++; if (alu_op !== 3'd0) begin bad++; $display("FAIL stall_op[%0d]: got=%0d want=0", i, alu_op); end
      total++; if (alu_b !== 4'd0) begin bad++; $display("FAIL stall_b[%0d]: got=%0d want=0", i, alu_b); end
      total++; if (res_data !== m_acc) begin bad++; $display("FAIL stall_acc[%0d]: got=%0d want=%0d", i, res_data, m_acc); end
      if (i == 0) begin @(posedge clk); #1; end
    end
    push_cmd(3'b101, 4'd4, 1'b1);
    wait_result(ok, g, e);
    total++;
    if (!ok) begin bad++; $display("FAIL stall_result: got=timeout want=result"); end
    else begin
      if (g[3:0] !== e[3:0]) begin bad++; $display("FAIL stall_data: got=%0d want=%0d", g[3:0], e[3:0]); end
      total++; if (g[7:4] !== e[7:4]) begin bad++; $display("FAIL stall_count: got=%0d want=%0d", g[7:4], e[7:4]); end
      total++; if (g[8] !== e[8]) begin bad++; $display("FAIL stall_ovf: got=%0b want=%0b", g[8], e[8]); end
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
    cmd_imm   = 4'd0;
    cmd_last  = 1'b0;
    res_ready = 1'b0;
    model_clear();
    test_reset();
    test_basic();
    test_ovf();
    test_backpressure();
    test_saturate();
    test_reset_midrun();
    test_stall();
    total++;
    if (got_q.size() != 0 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL leftover: got_q=%0d exp_q=%0d want=0", got_q.size(), exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
